// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: parametrised RPN evaluator with a register-file stack, restoring divider,
// sticky first-error reporting and a busy handshake towards the token parser.
module rpn_stack_engine #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             num_valid,
  input  logic [WIDTH-1:0] num_in,
  input  logic             op_valid,
  input  logic [3:0]       op_in,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic [2:0]       err_code,
  output logic [DW-1:0]    depth
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [DW-1:0] ONE = DW'(1);
  localparam logic [DW-1:0] TWO = DW'(2);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3, OP_MOD = 4'd4;
  localparam logic [3:0] OP_DUP = 4'd5, OP_SWAP = 4'd6, OP_DROP = 4'd7, OP_EVAL = 4'd15;
  localparam logic [2:0] E_NONE = 3'd0, E_UNF = 3'd1, E_OVF = 3'd2, E_DIV0 = 3'd3, E_ILL = 3'd4, E_OVR = 3'd5;
  typedef enum logic [1:0] {IDLE, EXEC, DIV, EMIT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] stk [DEPTH];
  logic [WIDTH-1:0] stk_n [DEPTH];
  logic [DW-1:0] depth_n;
  logic [3:0] op_q, op_n;
  logic [2:0] err, err_n, fault, eval_code;
  logic [WIDTH-1:0] dvs, dvs_n, rem, rem_n, quo, quo_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] result_n;
  logic error_n;
  logic [2:0] code_n;
  logic [AW-1:0] tos_i, nos_i, psh_i;
  logic [WIDTH-1:0] tos, nos, alu, d_rem, d_quo;
  logic [WIDTH:0] sh, diff;
  logic ge;
  assign tos_i = AW'(depth - ONE);
  assign nos_i = AW'(depth - TWO);
  assign psh_i = AW'(depth);
  assign tos = depth == '0 ? '0 : stk[tos_i];
  assign nos = stk[nos_i];
  assign alu = op_q == OP_ADD ? nos + tos : op_q == OP_SUB ? nos - tos : nos * tos;
  assign eval_code = err != E_NONE ? err : depth == '0 ? E_UNF : depth != ONE ? E_OVF : E_NONE;
  // one restoring-division step: the dividend shifts out of quo as quotient bits shift in
  assign sh = {rem, quo[WIDTH-1]};
  assign diff = sh - {1'b0, dvs};
  assign ge = !diff[WIDTH];
  assign d_rem = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign d_quo = {quo[WIDTH-2:0], ge};
  assign busy = state != IDLE;
  assign result_valid = state == EMIT;
  always_comb begin
    state_n = state;
    op_n = op_q;
    stk_n = stk;
    depth_n = depth;
    err_n = err;
    fault = E_NONE;
    dvs_n = dvs;
    rem_n = rem;
    quo_n = quo;
    cnt_n = cnt;
    result_n = result;
    error_n = error;
    code_n = err_code;
    case (state)
      IDLE: begin
        if (num_valid && depth == FULL) fault = E_OVF;
        else if (num_valid) begin
          stk_n[psh_i] = num_in;
          depth_n = depth + ONE;
        end
        if (op_valid) begin
          op_n = op_in;
          state_n = EXEC;
        end
      end
      EXEC: begin
        state_n = IDLE;
        if (op_q == OP_EVAL) begin
          state_n = EMIT;
          result_n = tos;
          code_n = eval_code;
          error_n = eval_code != E_NONE;
        end else if (err == E_NONE) begin
          case (op_q)
            OP_ADD, OP_SUB, OP_MUL: begin
              if (depth < TWO) fault = E_UNF;
              else begin
                stk_n[nos_i] = alu;
                depth_n = depth - ONE;
              end
            end
            OP_DIV, OP_MOD: begin
              if (depth < TWO) fault = E_UNF;
              else if (tos == '0) fault = E_DIV0;
              else begin
                state_n = DIV;
                dvs_n = tos;
                quo_n = nos;
                rem_n = '0;
                cnt_n = '0;
              end
            end
            OP_DUP: begin
              if (depth == '0) fault = E_UNF;
              else if (depth == FULL) fault = E_OVF;
              else begin
                stk_n[psh_i] = tos;
                depth_n = depth + ONE;
              end
            end
            OP_SWAP: begin
              if (depth < TWO) fault = E_UNF;
              else begin
                stk_n[nos_i] = tos;
                stk_n[tos_i] = nos;
              end
            end
            OP_DROP: begin
              if (depth == '0) fault = E_UNF;
              else depth_n = depth - ONE;
            end
            default: fault = E_ILL;
          endcase
        end
      end
      DIV: begin
        rem_n = d_rem;
        quo_n = d_quo;
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          state_n = IDLE;
          stk_n[nos_i] = op_q == OP_DIV ? d_quo : d_rem;
          depth_n = depth - ONE;
        end
      end
      EMIT: begin
        state_n = IDLE;
        depth_n = '0;
        err_n = E_NONE;
      end
    endcase
    // a token dropped during EMIT is charged to the expression that follows
    if (fault == E_NONE && busy && (num_valid || op_valid)) fault = E_OVR;
    if (err_n == E_NONE) err_n = fault;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q <= '0;
      stk <= '{default: '0};
      depth <= '0;
      err <= E_NONE;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      result <= '0;
      error <= 1'b0;
      err_code <= E_NONE;
    end else begin
      state <= state_n;
      op_q <= op_n;
      stk <= stk_n;
      depth <= depth_n;
      err <= err_n;
      dvs <= dvs_n;
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt_n;
      result <= result_n;
      error <= error_n;
      err_code <= code_n;
    end
  end
endmodule

// File: tb/tb_rpn_stack_engine.sv
// tb_rpn_stack_engine: table-driven, hand-sequenced and randomized checks of rpn_stack_engine
module tb_rpn_stack_engine;
  localparam int W = 16;
  localparam int D = 8;
  localparam longint MASK = (longint'(1) << W) - 1;
  logic clk = 1'b0;
  logic rst;
  logic num_valid, op_valid, busy, result_valid, error;
  logic [W-1:0] num_in, result;
  logic [3:0] op_in;
  logic [2:0] err_code;
  logic [3:0] depth;
  int errors = 0;
  int checks = 0;
  int rv_cnt = 0;
  logic [W-1:0] got_res;
  logic got_err;
  logic [2:0] got_code;
  typedef struct {
    bit nv;
    bit ov;
    logic [W-1:0] v;
    logic [3:0] o;
    int d;
    logic [W-1:0] r;
    bit e;
    logic [2:0] c;
  } vec_t;
  vec_t tbl[$];
  longint mq[$];
  int merr;
  rpn_stack_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .num_valid(num_valid), .num_in(num_in), .op_valid(op_valid),
    .op_in(op_in), .busy(busy), .result_valid(result_valid), .result(result), .error(error),
    .err_code(err_code), .depth(depth)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      rv_cnt++;
      got_res = result;
      got_err = error;
      got_code = err_code;
    end
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle;
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0d after %0d cycles, expected 0", busy, k);
    end
  endtask
  task automatic tok(input bit nv, input bit ov, input logic [W-1:0] v, input logic [3:0] o);
    num_valid = nv;
    op_valid = ov;
    num_in = v;
    op_in = o;
    tick();
    num_valid = 1'b0;
    op_valid = 1'b0;
  endtask
  task automatic run_row(input string tag, input vec_t r);
    int rv0;
    wait_idle();
    rv0 = rv_cnt;
    tok(r.nv, r.ov, r.v, r.o);
    wait_idle();
    check({tag, "_depth"}, 32'(depth), r.d);
    if (r.ov && r.o == 4'd15) begin
      check({tag, "_pulses"}, rv_cnt - rv0, 1);
      check({tag, "_result"}, got_res, r.r);
      check({tag, "_error"}, got_err, r.e);
      check({tag, "_code"}, got_code, r.c);
    end
  endtask
  function automatic void add_num(input longint v, input int d);
    tbl.push_back('{1'b1, 1'b0, W'(v), 4'd0, d, '0, 1'b0, 3'd0});
  endfunction
  function automatic void add_op(input int o, input int d);
    tbl.push_back('{1'b0, 1'b1, '0, 4'(o), d, '0, 1'b0, 3'd0});
  endfunction
  function automatic void add_both(input longint v, input int o, input int d);
    tbl.push_back('{1'b1, 1'b1, W'(v), 4'(o), d, '0, 1'b0, 3'd0});
  endfunction
  function automatic void add_eval(input longint r, input bit e, input int c);
    tbl.push_back('{1'b0, 1'b1, '0, 4'd15, 0, W'(r), e, 3'(c)});
  endfunction
  function automatic vec_t eval_row(input string dummy);
    vec_t r;
    int n;
    n = mq.size();
    r = '{1'b0, 1'b1, '0, 4'd15, 0, '0, 1'b0, 3'd0};
    r.r = n == 0 ? '0 : W'(mq[n-1]);
    r.c = merr != 0 ? 3'(merr) : n == 0 ? 3'd1 : n > 1 ? 3'd2 : 3'd0;
    r.e = r.c != 0;
    mq.delete();
    merr = 0;
    return r;
  endfunction
  function automatic void m_push(input longint v);
    if (mq.size() == D) merr = merr != 0 ? merr : 2;
    else mq.push_back(v);
  endfunction
  function automatic void m_op(input int o);
    longint a, b;
    int n;
    n = mq.size();
    if (merr != 0) return;
    if (o <= 4 || o == 6) begin
      if (n < 2) begin merr = 1; return; end
      if ((o == 3 || o == 4) && mq[n-1] == 0) begin merr = 3; return; end
      b = mq.pop_back();
      a = mq.pop_back();
      case (o)
        0: mq.push_back((a + b) & MASK);
        1: mq.push_back((a - b) & MASK);
        2: mq.push_back((a * b) & MASK);
        3: mq.push_back(a / b);
        4: mq.push_back(a % b);
        default: begin mq.push_back(b); mq.push_back(a); end
      endcase
    end else if (o == 5) begin
      if (n < 1) merr = 1;
      else if (n == D) merr = 2;
      else mq.push_back(mq[n-1]);
    end else if (o == 7) begin
      if (n < 1) merr = 1;
      else void'(mq.pop_back());
    end else merr = 4;
  endfunction
  initial begin
    int cyc, nt, r, o;
    bit nv, ov;
    logic [W-1:0] v;
    vec_t row;
    rst = 1'b1;
    num_valid = 1'b0;
    op_valid = 1'b0;
    num_in = '0;
    op_in = '0;
    merr = 0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_depth", depth, 0);
    check("rst_rv", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_error", error, 0);
    check("rst_code", err_code, 0);
    add_num(12, 1); add_num(12, 2); add_op(0, 1); add_num(3, 2); add_op(2, 1);
    add_num(2, 2); add_op(3, 1); add_eval(36, 0, 0);
    add_num(3, 1); add_num(5, 2); add_op(1, 1); add_eval(65534, 0, 0);
    add_num(7, 1); add_num(3, 2); add_op(4, 1); add_eval(1, 0, 0);
    add_num(4, 1); add_num(0, 2); add_op(3, 2); add_num(1, 3); add_op(0, 3); add_eval(1, 1, 3);
    add_num(5, 1); add_eval(5, 0, 0);
    add_op(0, 0); add_eval(0, 1, 1);
    add_op(0, 0); add_num(1, 1); add_num(0, 2); add_op(3, 2); add_eval(0, 1, 1);
    add_num(2, 1); add_op(5, 2); add_op(2, 1); add_num(7, 2); add_op(6, 2); add_op(1, 1);
    add_op(5, 2); add_op(7, 1); add_eval(3, 0, 0);
    add_num(9, 1); add_op(9, 1); add_eval(9, 1, 4);
    add_eval(0, 1, 1);
    add_num(1, 1); add_num(2, 2); add_eval(2, 1, 2);
    add_num(2, 1); add_both(9, 0, 1); add_eval(11, 0, 0);
    add_num(5, 1); add_num(3, 2); add_op(6, 2); add_op(3, 1); add_eval(0, 0, 0);
    add_num(100, 1); add_num(7, 2); add_op(4, 1); add_eval(2, 0, 0);
    add_num(65535, 1); add_num(65535, 2); add_op(2, 1); add_eval(1, 0, 0);
    add_num(65535, 1); add_num(1, 2); add_op(0, 1); add_eval(0, 0, 0);
    add_num(0, 1); add_op(5, 2); add_op(3, 2); add_eval(0, 1, 3);
    add_num(5, 1); add_op(6, 1); add_eval(5, 1, 1);
    add_op(7, 0); add_eval(0, 1, 1);
    foreach (tbl[i]) run_row("tbl", tbl[i]);
    for (int i = 1; i <= 9; i++) run_row("ovf", '{1'b1, 1'b0, W'(i), 4'd0, i > D ? D : i, '0, 1'b0, 3'd0});
    run_row("ovf", '{1'b0, 1'b1, '0, 4'd15, 0, W'(8), 1'b1, 3'd2});
    for (int i = 1; i <= 8; i++) run_row("dupovf", '{1'b1, 1'b0, W'(i), 4'd0, i, '0, 1'b0, 3'd0});
    run_row("dupovf", '{1'b0, 1'b1, '0, 4'd5, 8, '0, 1'b0, 3'd0});
    run_row("dupovf", '{1'b0, 1'b1, '0, 4'd15, 0, W'(8), 1'b1, 3'd2});
    run_row("divlat", '{1'b1, 1'b0, W'(7), 4'd0, 1, '0, 1'b0, 3'd0});
    run_row("divlat", '{1'b1, 1'b0, W'(3), 4'd0, 2, '0, 1'b0, 3'd0});
    tok(1'b0, 1'b1, '0, 4'd3);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    check("div_busy_cycles", cyc, W + 1);
    run_row("divlat", '{1'b0, 1'b1, '0, 4'd15, 0, W'(2), 1'b0, 3'd0});
    run_row("ovr", '{1'b1, 1'b0, W'(8), 4'd0, 1, '0, 1'b0, 3'd0});
    run_row("ovr", '{1'b1, 1'b0, W'(2), 4'd0, 2, '0, 1'b0, 3'd0});
    tok(1'b0, 1'b1, '0, 4'd3);
    repeat (3) tick();
    check("ovr_busy", busy, 1);
    tok(1'b0, 1'b1, '0, 4'd0);
    wait_idle();
    check("ovr_depth", depth, 1);
    run_row("ovr", '{1'b0, 1'b1, '0, 4'd15, 0, W'(4), 1'b1, 3'd5});
    run_row("rstdiv", '{1'b1, 1'b0, W'(100), 4'd0, 1, '0, 1'b0, 3'd0});
    run_row("rstdiv", '{1'b1, 1'b0, W'(7), 4'd0, 2, '0, 1'b0, 3'd0});
    tok(1'b0, 1'b1, '0, 4'd3);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("rstdiv_busy", busy, 0);
    check("rstdiv_depth", depth, 0);
    check("rstdiv_rv", result_valid, 0);
    check("rstdiv_result", result, 0);
    check("rstdiv_error", error, 0);
    check("rstdiv_code", err_code, 0);
    tick();
    rst = 1'b0;
    run_row("after", '{1'b1, 1'b0, W'(6), 4'd0, 1, '0, 1'b0, 3'd0});
    run_row("after", '{1'b1, 1'b0, W'(2), 4'd0, 2, '0, 1'b0, 3'd0});
    run_row("after", '{1'b0, 1'b1, '0, 4'd3, 1, '0, 1'b0, 3'd0});
    run_row("after", '{1'b0, 1'b1, '0, 4'd15, 0, W'(3), 1'b0, 3'd0});
    for (int e = 0; e < 40; e++) begin
      nt = $urandom_range(1, 8);
      for (int t = 0; t < nt; t++) begin
        r = $urandom_range(0, 9);
        v = r < 2 ? W'($urandom) : W'($urandom_range(0, 12));
        o = $urandom_range(0, 20) == 0 ? $urandom_range(8, 14) : $urandom_range(0, 7);
        nv = r < 5 || r == 9;
        ov = r >= 5;
        if (nv) m_push(longint'(v));
        if (ov) m_op(o);
        run_row("rand", '{nv, ov, v, 4'(o), mq.size(), '0, 1'b0, 3'd0});
      end
      row = eval_row("");
      run_row("rand_eval", row);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rpn_stack_engine.md
Name: rpn_stack_engine

Overview:
- Parametrised RPN evaluation core, fed by the UART token parser (number / operator tokens) and driving the result formatter / UART transmitter.
- Generalises the fixed 16-bit, fixed-depth RPN computer: configurable data width and stack depth, iterative divide/modulo, stack-manipulation ops, explicit error reporting and a busy handshake.

Parameters:
- WIDTH, 16, operand/result width in bits (unsigned, modulo 2^WIDTH arithmetic)
- DEPTH, 8, stack entries (>=2)
- DW, $clog2(DEPTH+1), width of depth output

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- num_valid  in  1  one-cycle pulse: num_in is a complete number token
- num_in  in  WIDTH  number token value
- op_valid  in  1  one-cycle pulse: op_in is an operator token
- op_in  in  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 DUP, 6 SWAP, 7 DROP, 15 EVAL (end of line); others illegal
- busy  out  1  engine cannot accept a token this cycle
- result_valid  out  1  one-cycle pulse on EVAL completion
- result  out  WIDTH  top of stack at EVAL; held until next result_valid
- error  out  1  qualifies result_valid: expression was in error
- err_code  out  3  0 none, 1 underflow, 2 overflow, 3 div-by-zero, 4 illegal op, 5 overrun; held with result
- depth  out  DW  current stack occupancy

Behaviour:
- Reset (async, any state, mid-divide included): state IDLE, stack empty, depth=0, busy=0, result_valid=0, result=0, error=0, err_code=0, sticky error cleared, pending op cleared.
- States: IDLE, EXEC, DIV, EMIT.
- Push: num_valid in IDLE -> TOS written at next edge, depth+1; busy stays 0. depth==DEPTH -> not pushed, sticky error OVERFLOW.
- Op accepted in IDLE -> EXEC for one cycle (busy=1 next cycle):
  - ADD/SUB/MUL: pop B (TOS), A; push low WIDTH bits of A op B; depth-1. Result visible on the cycle after EXEC; back to IDLE.
  - DUP: needs depth>=1, push copy; overflow rule applies. SWAP: needs depth>=2. DROP: needs depth>=1.
  - DIV/MOD: B==0 -> DIV0 error, stack unchanged; else DIV state: restoring divider, one quotient bit per cycle, WIDTH cycles, then push quotient (DIV) or remainder (MOD), depth-1, IDLE. busy high throughout EXEC+DIV (WIDTH+1 cycles).
  - Insufficient operands -> UNDERFLOW, stack unchanged. Illegal opcode -> ILLEGAL.
  - EVAL: EXEC -> EMIT; EMIT drives result_valid=1 for one cycle with result=TOS (0 if depth==0), error/err_code=sticky error; then stack cleared, depth=0, sticky error cleared, IDLE. depth!=1 at EVAL without prior error -> error, code UNDERFLOW (depth 0) or OVERFLOW (depth>1).
- Sticky error: first error code wins; later ops after an error are ignored (no stack change) except EVAL.
- Simultaneous num_valid and op_valid in IDLE: number pushed first, op held in a one-entry pending register and executed starting the next cycle (busy=1 that cycle).
- Token (num or op) arriving while busy=1: dropped, sticky OVERRUN (unless an earlier error is recorded).
- Arithmetic unsigned; SUB wraps (3-5 = 2^WIDTH-2); MUL truncated.

Test Plan:
- Tokens 12,12,ADD,3,MUL,2,DIV,EVAL spaced >=WIDTH+2 cycles -> one result_valid, result=36, error=0, depth=0 afterward.
- 3,5,SUB,EVAL (WIDTH=16) -> result=65534, error=0; 7,3,MOD,EVAL -> result=1; DIV busy exactly 17 cycles.
- 4,0,DIV,1,ADD,EVAL -> result_valid with error=1, err_code=3; next 5,EVAL -> result=5, error=0.
- DEPTH=8: nine pushes then EVAL -> err_code=2, depth capped at 8; ADD on empty stack then EVAL -> err_code=1.
- num_valid and op_valid(ADD) same cycle with stack {2} and num 9 -> TOS 11, depth 1; op_valid during DIV busy -> err_code=5 at EVAL.
- rst asserted mid-DIV -> outputs immediately zero, depth=0; subsequent 6,2,DIV,EVAL -> result=3.
